// File: rtl/cpu_pkg.sv
// Shared types and constants for the 16-bit pipelined CPU.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package cpu_pkg;

  localparam int PC_W   = 16;
  localparam int INST_W = 16;

  localparam logic [PC_W-1:0]   RESET_PC    = 16'h0000;
  localparam logic [INST_W-1:0] NOP_INST    = 16'h0000;
  localparam logic [3:0]        HALT_OPCODE = 4'hF;

  // Opcode field position inside an instruction word
  localparam int OPC_MSB = 15;
  localparam int OPC_LSB = 12;

  typedef enum logic [2:0] {
    FS_ISSUE,
    FS_WAIT,
    FS_HOLD,
    FS_DROP,
    FS_HALTED
  } fetchState_t;

  function automatic logic isHalt(input logic [INST_W-1:0] instr,
                                  input logic [3:0]        haltOpc);
    return instr[OPC_MSB:OPC_LSB] == haltOpc;
  endfunction

endpackage

// File: rtl/if_hold_buf.sv
// One-entry holding register for an instruction response that arrived while decode stalled.
// Latency: 1 cycle (load visible the cycle after the load strobe).
// Backpressure: none; the owner decides when to load and when to clear (clear wins).
//
// Ports:
//   clk, rst_n  clock, async active-low reset
//   load, dIn   capture dIn and mark the entry valid
//   clear       drop the entry
//   valid, data entry state and contents
module if_hold_buf
  import cpu_pkg::*;
#(
  parameter int W = INST_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic         clear,
  input  logic [W-1:0] dIn,
  output logic         valid,
  output logic [W-1:0] data
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= dIn;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction fetch stage: owns the PC, talks to instruction memory, fills the IF/ID register.
// Latency: memory latency + 1 cycle to IF/ID; back-to-back fetch gives 1 instr/cycle at memory latency 1.
// Backpressure: stall holds IF/ID; a response arriving under stall is parked in if_hold_buf and no new request issues.
//
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   stall                      decode cannot accept; IF/ID holds
//   redirect, redirect_pc      taken branch/jump: flush and refetch from redirect_pc
//   imem_req, imem_addr        memory request (one outstanding)
//   imem_rvalid, imem_rdata    in-order memory response
//   ifid_*                     IF/ID pipeline register
//   pc                         current fetch PC (HLT address once halted)
//   halt_fetched               HLT fetched, fetch stopped
module if_stage
  import cpu_pkg::*;
#(
  parameter logic [PC_W-1:0]   RESET_PC_P    = RESET_PC,
  parameter logic [3:0]        HALT_OPCODE_P = HALT_OPCODE,
  parameter logic [INST_W-1:0] NOP_INST_P    = NOP_INST
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic [INST_W-1:0] imem_rdata,
  input  logic              imem_rvalid,
  output logic              ifid_valid,
  output logic [INST_W-1:0] ifid_instr,
  output logic [PC_W-1:0]   ifid_pc,
  output logic [PC_W-1:0]   ifid_pc_plus2,
  output logic [PC_W-1:0]   pc,
  output logic              halt_fetched
);

  fetchState_t       state;
  logic [PC_W-1:0]   pcPlus2;
  logic              accept;
  logic              respHalt;
  logic              holdLoad;
  logic              holdClear;
  logic              holdValid;
  logic [INST_W-1:0] holdData;
  logic              holdHalt;

  // Wraps modulo 2^PC_W
  assign pcPlus2  = pc + PC_W'(2);
  assign accept   = (state == FS_WAIT) && imem_rvalid && !redirect && !stall;
  assign respHalt = isHalt(imem_rdata, HALT_OPCODE_P);
  assign holdHalt = isHalt(holdData, HALT_OPCODE_P);

  assign holdLoad  = (state == FS_WAIT) && imem_rvalid && stall && !redirect;
  assign holdClear = redirect || ((state == FS_HOLD) && !stall);

  if_hold_buf #(.W(INST_W)) u_holdBuf (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (holdLoad),
    .clear (holdClear),
    .dIn   (imem_rdata),
    .valid (holdValid),
    .data  (holdData)
  );

  // Request is combinational so an accepted response can launch the next
  // fetch in the same cycle. In WAIT, pc is the address of the outstanding request.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc;
    if (rst_n) begin
      case (state)
        FS_ISSUE: imem_req = !redirect;
        FS_WAIT: begin
          if (accept && !respHalt) begin
            imem_req  = 1'b1;
            imem_addr = pcPlus2;
          end
        end
        default: imem_req = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= FS_ISSUE;
      pc            <= RESET_PC_P;
      ifid_valid    <= 1'b0;
      ifid_instr    <= NOP_INST_P;
      ifid_pc       <= '0;
      ifid_pc_plus2 <= '0;
      halt_fetched  <= 1'b0;
    end else if (redirect) begin
      ifid_valid   <= 1'b0;
      ifid_instr   <= NOP_INST_P;
      halt_fetched <= 1'b0;
      pc           <= redirect_pc;
      // A request still in flight must have its response swallowed in DROP
      if ((state == FS_WAIT || state == FS_DROP) && !imem_rvalid)
        state <= FS_DROP;
      else
        state <= FS_ISSUE;
    end else begin
      case (state)
        FS_ISSUE: begin
          state <= FS_WAIT;
          if (!stall) ifid_valid <= 1'b0;
        end
        FS_WAIT: begin
          if (imem_rvalid) begin
            if (stall) begin
              state <= FS_HOLD;
            end else begin
              ifid_valid    <= 1'b1;
              ifid_instr    <= imem_rdata;
              ifid_pc       <= pc;
              ifid_pc_plus2 <= pcPlus2;
              if (respHalt) begin
                state        <= FS_HALTED;
                halt_fetched <= 1'b1;
              end else begin
                pc <= pcPlus2;
              end
            end
          end else if (!stall) begin
            ifid_valid <= 1'b0;
          end
        end
        FS_HOLD: begin
          if (!stall && holdValid) begin
            ifid_valid    <= 1'b1;
            ifid_instr    <= holdData;
            ifid_pc       <= pc;
            ifid_pc_plus2 <= pcPlus2;
            if (holdHalt) begin
              state        <= FS_HALTED;
              halt_fetched <= 1'b1;
            end else begin
              pc    <= pcPlus2;
              state <= FS_ISSUE;
            end
          end
        end
        FS_DROP: begin
          if (imem_rvalid) state <= FS_ISSUE;
          if (!stall) ifid_valid <= 1'b0;
        end
        FS_HALTED: begin
          if (!stall) ifid_valid <= 1'b0;
        end
        default: state <= FS_ISSUE;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage with a latency-1 instruction memory model.
// Latency: n/a.
// Backpressure: bench drives stall/redirect and can withhold memory responses.
module tb_if_stage;
  import cpu_pkg::*;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              stall;
  logic              redirect;
  logic [PC_W-1:0]   redirect_pc;
  logic              imem_req;
  logic [PC_W-1:0]   imem_addr;
  logic [INST_W-1:0] imem_rdata;
  logic              imem_rvalid;
  logic              ifid_valid;
  logic [INST_W-1:0] ifid_instr;
  logic [PC_W-1:0]   ifid_pc;
  logic [PC_W-1:0]   ifid_pc_plus2;
  logic [PC_W-1:0]   pc;
  logic              halt_fetched;

  always #5 clk = ~clk;

  if_stage dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .redirect      (redirect),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .imem_rvalid   (imem_rvalid),
    .ifid_valid    (ifid_valid),
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc),
    .ifid_pc_plus2 (ifid_pc_plus2),
    .pc            (pc),
    .halt_fetched  (halt_fetched)
  );

  int          nChecks = 0;
  int          nFails  = 0;
  logic        respPend = 1'b0;
  logic [15:0] respAddr = 16'h0;
  logic        respEn   = 1'b1;
  logic        reqSeen;
  logic [15:0] addrSeen;
  int          reqCnt;

  function automatic logic [15:0] memWord(input logic [15:0] a);
    case (a)
      16'h0000: return 16'h1111;
      16'h0002: return 16'h2222;
      16'h0004: return 16'h3333;
      16'h0006: return 16'hF000;
      16'hFFFE: return 16'h7FFE;
      default:  return {4'h2, a[11:0]};
    endcase
  endfunction

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nFails++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One clock: drive inputs at the negedge, sample the request, let the edge
  // pass, update the memory model, and return at the next negedge.
  task automatic step(input logic st, input logic rd, input logic [15:0] rpc);
    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_rvalid = respPend && respEn;
    imem_rdata  = imem_rvalid ? memWord(respAddr) : 16'h0;
    #1;
    reqSeen  = imem_req;
    addrSeen = imem_addr;
    @(posedge clk);
    if (imem_rvalid) respPend = 1'b0;
    if (reqSeen) begin
      respPend = 1'b1;
      respAddr = addrSeen;
    end
    @(negedge clk);
    stall       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 16'h0;
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] expInstr [3];
    expInstr[0] = 16'h1111;
    expInstr[1] = 16'h2222;
    expInstr[2] = 16'h3333;

    rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 16'h0;
    imem_rvalid = 1'b0; imem_rdata = 16'h0;
    #1;
    checkVal("rst_req",    imem_req,      0);
    checkVal("rst_valid",  ifid_valid,    0);
    checkVal("rst_instr",  ifid_instr,    16'h0000);
    checkVal("rst_ifpc",   ifid_pc,       0);
    checkVal("rst_plus2",  ifid_pc_plus2, 0);
    checkVal("rst_pc",     pc,            16'h0000);
    checkVal("rst_halt",   halt_fetched,  0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Streaming fetch
    step(0, 0, 0);
    checkVal("s_req0",  reqSeen,  1);
    checkVal("s_addr0", addrSeen, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0);
      checkVal("s_addr",  addrSeen,   16'(2 * (i + 1)));
      checkVal("s_ifpc",  ifid_pc,    16'(2 * i));
      checkVal("s_instr", ifid_instr, expInstr[i]);
      checkVal("s_valid", ifid_valid, 1);
    end

    // HLT at 0x0006
    step(0, 0, 0);
    checkVal("h_req",   reqSeen,       0);
    checkVal("h_instr", ifid_instr,    16'hF000);
    checkVal("h_halt",  halt_fetched,  1);
    checkVal("h_pc",    pc,            16'h0006);
    checkVal("h_plus2", ifid_pc_plus2, 16'h0008);
    step(1, 0, 0);
    checkVal("h_keep_valid", ifid_valid, 1);
    reqCnt = 0;
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0);
      reqCnt += int'(reqSeen);
    end
    checkVal("h_no_req",  reqCnt,       0);
    checkVal("h_bubble",  ifid_valid,   0);
    checkVal("h_halt2",   halt_fetched, 1);
    checkVal("h_pc2",     pc,           16'h0006);
    step(0, 1, 16'h0010);
    checkVal("h_unhalt",  halt_fetched, 0);
    checkVal("h_redir_pc", pc,          16'h0010);
    step(0, 0, 0);
    checkVal("h_addr10",  addrSeen,     16'h0010);
    step(0, 0, 0);
    checkVal("h_instr10", ifid_instr,   16'h2010);

    // Redirect in WAIT with no response; stale response follows
    respEn = 1'b0;
    step(0, 1, 16'h0040);
    checkVal("d_req",   reqSeen,    0);
    checkVal("d_valid", ifid_valid, 0);
    checkVal("d_pc",    pc,         16'h0040);
    respEn = 1'b1;
    step(0, 0, 0);
    checkVal("d_stale_req",   reqSeen,    0);
    checkVal("d_stale_valid", ifid_valid, 0);
    checkVal("d_stale_instr", ifid_instr, 16'h0000);
    step(0, 0, 0);
    checkVal("d_addr40", addrSeen, 16'h0040);
    step(0, 0, 0);
    checkVal("d_instr40", ifid_instr, 16'h2040);
    checkVal("d_ifpc40",  ifid_pc,    16'h0040);

    // Redirect coinciding with a response, then PC wrap at 0xFFFE
    step(0, 1, 16'hFFFE);
    checkVal("w_valid", ifid_valid, 0);
    checkVal("w_req",   reqSeen,    0);
    step(0, 0, 0);
    checkVal("w_addr",  addrSeen,   16'hFFFE);
    step(0, 0, 0);
    checkVal("w_next_addr", addrSeen,      16'h0000);
    checkVal("w_plus2",     ifid_pc_plus2, 16'h0000);
    checkVal("w_ifpc",      ifid_pc,       16'hFFFE);
    checkVal("w_instr",     ifid_instr,    16'h7FFE);

    // Stall as 0x2222 arrives, held 3 cycles
    step(0, 0, 0);
    checkVal("t_instr1111", ifid_instr, 16'h1111);
    for (int i = 0; i < 3; i++) begin
      step(1, 0, 0);
      checkVal("t_stall_req",   reqSeen,    0);
      checkVal("t_stall_instr", ifid_instr, 16'h1111);
    end
    step(0, 0, 0);
    checkVal("t_rel_instr", ifid_instr, 16'h2222);
    checkVal("t_rel_ifpc",  ifid_pc,    16'h0002);
    checkVal("t_rel_valid", ifid_valid, 1);
    checkVal("t_rel_req",   reqSeen,    0);
    step(0, 0, 0);
    checkVal("t_addr4",  addrSeen,   16'h0004);
    checkVal("t_bubble", ifid_valid, 0);

    // Reset dropped mid-WAIT between edges
    imem_rvalid = 1'b1;
    imem_rdata  = memWord(16'h0004);
    #1;
    checkVal("r_pre_req", imem_req, 1);
    rst_n = 1'b0;
    #1;
    checkVal("r_req",   imem_req,   0);
    checkVal("r_valid", ifid_valid, 0);
    checkVal("r_pc",    pc,         16'h0000);
    checkVal("r_instr", ifid_instr, 16'h0000);
    imem_rvalid = 1'b0;
    imem_rdata  = 16'h0;
    respPend    = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    step(0, 0, 0);
    checkVal("r_first_req",  reqSeen,  1);
    checkVal("r_first_addr", addrSeen, 16'h0000);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

endmodule
